// File: rtl/sseg_pkg.sv
// Shared types and segment patterns for the stopwatch seven-segment display.
// Optional blink support in the top is enabled with SSEG_BLINK_EN.
package sseg_pkg;

    typedef enum logic [1:0] {
        UP_WAIT   = 2'b00,
        UP_RUN    = 2'b01,
        DOWN_WAIT = 2'b10,
        DOWN_RUN  = 2'b11
    } sw_state_e;

    typedef enum logic {
        LAP_OFF = 1'b0,
        LAP_ON  = 1'b1
    } lap_state_e;

    // Bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b011_1111;
    localparam logic [6:0] SEG_1     = 7'b000_0110;
    localparam logic [6:0] SEG_2     = 7'b101_1011;
    localparam logic [6:0] SEG_3     = 7'b100_1111;
    localparam logic [6:0] SEG_4     = 7'b110_0110;
    localparam logic [6:0] SEG_5     = 7'b110_1101;
    localparam logic [6:0] SEG_6     = 7'b111_1100;
    localparam logic [6:0] SEG_7     = 7'b010_0111;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b110_1111;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_DASH  = 7'b100_0000;

    function automatic logic is_up(input logic [1:0] s);
        return (s == UP_WAIT) || (s == UP_RUN);
    endfunction

    function automatic logic is_down(input logic [1:0] s);
        return (s == DOWN_WAIT) || (s == DOWN_RUN);
    endfunction

    function automatic logic is_wait(input logic [1:0] s);
        return (s == UP_WAIT) || (s == DOWN_WAIT);
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// BCD nibble to seven-segment pattern; codes above 9 display blank.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with lap snapshot and zero blanking.
// Define SSEG_BLINK_EN to blink the display in the wait states.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int DP_POS    = 2,
    parameter int LZ_BLANK  = 1,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            current_state,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic                  lap_toggle,
    input  logic                  lap_capture,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  lap_on
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic                  tick;

    lap_state_e            lap_q;
    lap_state_e            lap_d;
    logic                  snap_load;
    logic [4*N_DIGITS-1:0] snap;

    logic [4*N_DIGITS-1:0] src;
    logic [N_DIGITS-1:0]   zero_up;
    logic [3:0]            nib;
    logic                  blank;
    logic [6:0]            seg_raw;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
    logic                  dark;

    assign tick = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            if (tick) begin
                presc <= '0;
                idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Down-counting states override any toggle request
    always_comb begin
        lap_d     = lap_q;
        snap_load = 1'b0;
        if (is_down(current_state)) begin
            lap_d = LAP_OFF;
        end else begin
            unique case (lap_q)
                LAP_OFF: begin
                    if (lap_toggle && is_up(current_state)) begin
                        lap_d     = LAP_ON;
                        snap_load = 1'b1;
                    end
                end
                LAP_ON: begin
                    if (lap_toggle) begin
                        lap_d = LAP_OFF;
                    end else if (lap_capture) begin
                        snap_load = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q <= LAP_OFF;
            snap  <= '0;
        end else begin
            lap_q <= lap_d;
            if (snap_load) begin
                snap <= digits_in;
            end
        end
    end

    assign lap_on = (lap_q == LAP_ON);
    assign src    = lap_on ? snap : digits_in;

    // zero_up[i]: digit i and every digit above it are zero
    always_comb begin
        zero_up = '0;
        zero_up[N_DIGITS-1] = (src[4*N_DIGITS-1 -: 4] == 4'd0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            zero_up[i] = zero_up[i+1] && (src[4*i +: 4] == 4'd0);
        end
    end

    assign nib   = src[{idx, 2'b00} +: 4];
    assign blank = (LZ_BLANK != 0) && (idx != '0) && zero_up[idx];

    sseg_decode u_decode (
        .bcd (nib),
        .seg (seg_raw)
    );

    assign seg_nxt = blank ? SEG_BLANK : seg_raw;
    assign dp_nxt  = (int'(idx) == DP_POS);
    assign an_nxt  = N_DIGITS'(1) << idx;

`ifdef SSEG_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign dark = blink_off && is_wait(current_state);
`else
    // Without blinking the display is never dark; BLINK_DIV has no role
    assign dark = (BLINK_DIV < 0);
`endif

    // seg, dp and an share one register stage so digits never ghost
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_DASH;
            dp  <= 1'b0;
            an  <= N_DIGITS'(1);
        end else if (dark) begin
            seg <= SEG_BLANK;
            dp  <= 1'b0;
            an  <= '0;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

endmodule
